// File: rtl/pq_rr_arb_if.sv
// pq_rr_arb_if -- request/grant bundle for the pq_rr_arb arbiter.
//   master : requester side, drives req_vec, rr_mode, grant_ack (and lock)
//   slave  : arbiter side, drives grant_vec, grant_valid, grant_idx
// Optional feature macro: PQ_RR_ARB_LOCK_EN adds the lock request line.
interface pq_rr_arb_if #(
   parameter int WIDTH = 14,
   parameter int IDX_W = $clog2(WIDTH)
);
   logic [WIDTH-1:0] req_vec;
   logic             rr_mode;
   logic             grant_ack;
`ifdef PQ_RR_ARB_LOCK_EN
   logic             lock;
`endif
   logic [WIDTH-1:0] grant_vec;
   logic             grant_valid;
   logic [IDX_W-1:0] grant_idx;

`ifdef PQ_RR_ARB_LOCK_EN
   modport master (output req_vec, rr_mode, grant_ack, lock,
                   input  grant_vec, grant_valid, grant_idx);
   modport slave  (input  req_vec, rr_mode, grant_ack, lock,
                   output grant_vec, grant_valid, grant_idx);
`else
   modport master (output req_vec, rr_mode, grant_ack,
                   input  grant_vec, grant_valid, grant_idx);
   modport slave  (input  req_vec, rr_mode, grant_ack,
                   output grant_vec, grant_valid, grant_idx);
`endif
endinterface

// File: rtl/pq_rr_arb.sv
// pq_rr_arb -- zero-latency arbiter with rotating or fixed priority.
//   CLK  : clock, all state on rising edge
//   nRST : asynchronous active-low reset; also forces grant outputs to zero
//   bus  : pq_rr_arb_if.slave (req_vec, rr_mode, grant_ack, [lock] in;
//          grant_vec, grant_valid, grant_idx out)
// Optional feature macro: PQ_RR_ARB_LOCK_EN enables grant locking, where an
// acknowledged grant taken with lock=1 keeps ownership until lock drops or
// the owner withdraws its request.
module pq_rr_arb #(
   parameter int WIDTH = 14,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic         CLK,
   input  logic         nRST,
   pq_rr_arb_if.slave   bus
);

   logic [IDX_W-1:0] ptr;
   logic             arb_hit;
   logic [IDX_W-1:0] arb_idx;
   logic [IDX_W:0]   pos;
   logic             gnt_valid;
   logic [IDX_W-1:0] gnt_idx;

`ifdef PQ_RR_ARB_LOCK_EN
   logic             locked;
   logic [IDX_W-1:0] lock_owner;
`endif

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
      return (i == IDX_W'(WIDTH - 1)) ? '0 : i + 1'b1;
   endfunction

   // Search WIDTH positions starting at ptr (rotating) or 0 (fixed); pos is
   // one bit wider so ptr+k cannot overflow before the wrap subtraction.
   always_comb begin
      arb_hit = 1'b0;
      arb_idx = '0;
      pos     = '0;
      for (int unsigned k = 0; k < WIDTH; k++) begin
         if (bus.rr_mode) begin
            pos = {1'b0, ptr} + (IDX_W+1)'(k);
            if (pos >= (IDX_W+1)'(WIDTH))
               pos = pos - (IDX_W+1)'(WIDTH);
         end else begin
            pos = (IDX_W+1)'(k);
         end
         if (!arb_hit && bus.req_vec[pos[IDX_W-1:0]]) begin
            arb_hit = 1'b1;
            arb_idx = pos[IDX_W-1:0];
         end
      end
`ifdef PQ_RR_ARB_LOCK_EN
      // While locked only the owner may be granted, and only while it requests.
      if (locked) begin
         arb_hit = bus.req_vec[lock_owner];
         arb_idx = lock_owner;
      end
`endif
   end

   always_comb begin
      gnt_valid       = nRST && arb_hit;
      gnt_idx         = gnt_valid ? arb_idx : '0;
      bus.grant_valid = gnt_valid;
      bus.grant_idx   = gnt_idx;
      bus.grant_vec   = gnt_valid ? ({{(WIDTH-1){1'b0}}, 1'b1} << gnt_idx) : '0;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ptr        <= '0;
`ifdef PQ_RR_ARB_LOCK_EN
         locked     <= 1'b0;
         lock_owner <= '0;
`endif
      end else begin
`ifdef PQ_RR_ARB_LOCK_EN
         if (locked) begin
            if (!bus.lock || !bus.req_vec[lock_owner]) begin
               locked <= 1'b0;
               ptr    <= wrap_inc(lock_owner);
            end
         end else if (gnt_valid && bus.grant_ack) begin
            ptr <= wrap_inc(gnt_idx);
            if (bus.lock) begin
               locked     <= 1'b1;
               lock_owner <= gnt_idx;
            end
         end
`else
         if (gnt_valid && bus.grant_ack)
            ptr <= wrap_inc(gnt_idx);
`endif
      end
   end

endmodule

// File: tb/tb_pq_rr_arb.sv
// tb_pq_rr_arb -- self-checking bench for pq_rr_arb (WIDTH=14).
// Directed table, multi-cycle corner sequences, then random traffic checked
// against a rotate-and-search reference model. Lock checks are built only
// when PQ_RR_ARB_LOCK_EN is defined.
module tb_pq_rr_arb;
   localparam int W  = 14;
   localparam int IW = $clog2(W);

   logic CLK;
   logic nRST;

   pq_rr_arb_if #(.WIDTH(W), .IDX_W(IW)) bus ();

   pq_rr_arb #(.WIDTH(W), .IDX_W(IW)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_bad = 0;

   // reference model state
   int m_ptr    = 0;
   bit m_locked = 1'b0;
   int m_owner  = 0;

   typedef struct {
      logic [W-1:0] req;
      bit           rr;
      bit           ack;
      int           exp;   // granted index, -1 for no grant
   } vec_t;

   vec_t tbl[17];

   function automatic int model_grant(input logic [W-1:0] req, input bit rr);
      logic [2*W-1:0] dbl;
      logic [W-1:0]   rot;
      int             base;
      if (m_locked) return req[m_owner] ? m_owner : -1;
      base = rr ? m_ptr : 0;
      dbl  = {req, req} >> base;
      rot  = dbl[W-1:0];
      for (int j = 0; j < W; j++)
         if (rot[j]) return (base + j) % W;
      return -1;
   endfunction

   task automatic model_clock(input logic [W-1:0] req, input bit rr, input bit ack, input bit lk);
      int g;
      g = model_grant(req, rr);
      if (m_locked) begin
         if (!lk || !req[m_owner]) begin
            m_locked = 1'b0;
            m_ptr    = (m_owner + 1) % W;
         end
      end else if (g >= 0 && ack) begin
         m_ptr = (g + 1) % W;
         if (lk) begin
            m_locked = 1'b1;
            m_owner  = g;
         end
      end
   endtask

   task automatic check(input string name, input int exp);
      logic [W-1:0]  ev;
      logic [IW-1:0] ei;
      logic          evld;
      evld = (exp >= 0);
      ev   = evld ? (W'(1) << exp) : '0;
      ei   = evld ? IW'(exp) : '0;
      n_vec++;
      if (bus.grant_vec !== ev) begin
         n_bad++;
         $display("FAIL %s grant_vec: got %h expected %h", name, bus.grant_vec, ev);
      end
      n_vec++;
      if (bus.grant_valid !== evld) begin
         n_bad++;
         $display("FAIL %s grant_valid: got %b expected %b", name, bus.grant_valid, evld);
      end
      n_vec++;
      if (bus.grant_idx !== ei) begin
         n_bad++;
         $display("FAIL %s grant_idx: got %0d expected %0d", name, bus.grant_idx, ei);
      end
   endtask

   task automatic drive(input logic [W-1:0] req, input bit rr, input bit ack, input bit lk);
      bus.req_vec   = req;
      bus.rr_mode   = rr;
      bus.grant_ack = ack;
`ifdef PQ_RR_ARB_LOCK_EN
      bus.lock      = lk;
`endif
   endtask

   // One clock: apply inputs, check mid-cycle, then advance model and DUT.
   task automatic step(input logic [W-1:0] req, input bit rr, input bit ack, input bit lk,
                       input string name, input int exp);
      drive(req, rr, ack, lk);
      @(negedge CLK);
      check(name, exp);
      model_clock(req, rr, ack, lk);
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      drive('0, 1'b1, 1'b0, 1'b0);
      nRST = 1'b0;
      m_ptr = 0; m_locked = 1'b0; m_owner = 0;
      repeat (2) @(posedge CLK);
      #1;
      drive(14'h3FFF, 1'b1, 1'b1, 1'b1);
      #1;
      check("reset_hold", -1);
      drive('0, 1'b1, 1'b0, 1'b0);
      @(posedge CLK);
      #1;
      nRST = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] rq;
      bit rr, ak, lk;
      int e;

      tbl[0]  = '{14'h0000, 1'b1, 1'b1, -1};
      tbl[1]  = '{14'h0004, 1'b1, 1'b0,  2};
      tbl[2]  = '{14'h0004, 1'b1, 1'b0,  2};
      tbl[3]  = '{14'h0004, 1'b1, 1'b0,  2};
      tbl[4]  = '{14'h0000, 1'b1, 1'b1, -1};
      tbl[5]  = '{14'h3FFF, 1'b1, 1'b0,  0};
      tbl[6]  = '{14'h0010, 1'b1, 1'b1,  4};
      tbl[7]  = '{14'h0010, 1'b1, 1'b0,  4};
      tbl[8]  = '{14'h0011, 1'b1, 1'b0,  0};
      tbl[9]  = '{14'h0100, 1'b1, 1'b1,  8};
      tbl[10] = '{14'h0600, 1'b0, 1'b0,  9};
      tbl[11] = '{14'h0601, 1'b0, 1'b0,  0};
      tbl[12] = '{14'h0601, 1'b1, 1'b0,  9};
      tbl[13] = '{14'h2000, 1'b1, 1'b1, 13};
      tbl[14] = '{14'h3FFF, 1'b1, 1'b0,  0};
      tbl[15] = '{14'h0003, 1'b0, 1'b1,  0};
      tbl[16] = '{14'h0003, 1'b1, 1'b0,  1};

      do_reset();
      for (int i = 0; i < 17; i++)
         step(tbl[i].req, tbl[i].rr, tbl[i].ack, 1'b0, $sformatf("tbl%0d", i), tbl[i].exp);

      // full rotation with everyone requesting, wrap back to 0
      do_reset();
      for (int i = 0; i < 15; i++)
         step(14'h3FFF, 1'b1, 1'b1, 1'b0, $sformatf("sweep%0d", i), i % W);

`ifdef PQ_RR_ARB_LOCK_EN
      do_reset();
      step(14'h0008, 1'b1, 1'b1, 1'b1, "lock_take", 3);
      for (int i = 0; i < 4; i++)
         step(14'h3FFF, 1'b1, 1'b1, 1'b1, $sformatf("lock_hold%0d", i), 3);
      step(14'h3FFF, 1'b1, 1'b0, 1'b0, "lock_drop", 3);
      step(14'h3FFF, 1'b1, 1'b0, 1'b0, "lock_after", 4);
`endif

      // asynchronous reset in the middle of a cycle, with ptr advanced to 7
      do_reset();
      step(14'h0040, 1'b1, 1'b1, 1'b1, "pre_rst", 6);
      drive(14'h0080, 1'b1, 1'b0, 1'b1);
      #1;
      nRST = 1'b0;
      #1;
      check("rst_async", -1);
      m_ptr = 0; m_locked = 1'b0; m_owner = 0;
      @(posedge CLK);
      #1;
      nRST = 1'b1;
      step(14'h0080, 1'b1, 1'b0, 1'b0, "post_rst", 7);

      for (int i = 0; i < 1500; i++) begin
         case ($urandom_range(0, 5))
            0:       rq = '0;
            1, 2:    rq = W'(1) << $urandom_range(0, W - 1);
            default: rq = W'($urandom);
         endcase
         rr = 1'($urandom_range(0, 3) != 0);
         ak = 1'($urandom_range(0, 1));
`ifdef PQ_RR_ARB_LOCK_EN
         lk = 1'($urandom_range(0, 3) == 0);
`else
         lk = 1'b0;
`endif
         e = model_grant(rq, rr);
         step(rq, rr, ak, lk, "rand", e);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
